// File: rtl/riscv_imm_pkg.sv
// Immediate-format codes and RV32/RV64 base opcode constants shared by
// the decoder and the decode stage.
package riscv_imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: classifies the opcode, assembles the
// 32-bit immediate for its format and extends it to XLEN.
module imm_decode
    import riscv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    imm_type_e   fmt;
    logic [31:0] imm32;
    logic [6:0]  opcode;
    logic        unused_funct3;

    assign opcode        = instr[6:0];
    assign unused_funct3 = ^instr[13:12];
    assign imm_type      = fmt;

    always_comb begin
        fmt     = IMM_NONE;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI, OPC_AUIPC:                fmt = IMM_U;
                OPC_JAL:                           fmt = IMM_J;
                OPC_BRANCH:                        fmt = IMM_B;
                OPC_JALR, OPC_LOAD, OPC_OP_IMM:    fmt = IMM_I;
                OPC_STORE:                         fmt = IMM_S;
                OPC_SYSTEM:                        fmt = instr[14] ? IMM_Z : IMM_I;
                OPC_OP, OPC_MISC_MEM:              fmt = IMM_NONE;
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) fmt = IMM_I;
                    else            illegal = 1'b1;
                end
                OPC_OP_32: begin
                    if (XLEN != 64) illegal = 1'b1;
                end
                default:                           illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Z is the only zero-extended format; everything else carries instr[31] up to XLEN.
    always_comb begin
        if (fmt == IMM_Z) imm = XLEN'(instr[19:15]);
        else              imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: decodes at the input and buffers results in
// a two-entry skid buffer (output register + skid register) with flush.
module imm_decode_stage
    import riscv_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_imm_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            dec_illegal;

    logic            out_v;
    logic            skid_v;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_type;
    logic            skid_illegal;

    logic            accept;
    logic            deliver;
    logic            load_out;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr    (in_instr),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign in_ready  = !skid_v;
    assign out_valid = out_v;
    assign accept    = in_valid && in_ready && !flush;
    assign deliver   = out_v && out_ready;
    assign load_out  = !out_v || out_ready;

    // Skid only fills while the output register is held; it drains first on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v        <= 1'b0;
            skid_v       <= 1'b0;
            out_instr    <= '0;
            out_imm      <= '0;
            out_imm_type <= IMM_NONE;
            out_illegal  <= 1'b0;
            skid_instr   <= '0;
            skid_imm     <= '0;
            skid_type    <= IMM_NONE;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (load_out) begin
            if (skid_v) begin
                out_v        <= 1'b1;
                skid_v       <= 1'b0;
                out_instr    <= skid_instr;
                out_imm      <= skid_imm;
                out_imm_type <= skid_type;
                out_illegal  <= skid_illegal;
            end else begin
                out_v <= accept;
                if (accept) begin
                    out_instr    <= in_instr;
                    out_imm      <= dec_imm;
                    out_imm_type <= dec_type;
                    out_illegal  <= dec_illegal;
                end
            end
        end else if (accept) begin
            skid_v       <= 1'b1;
            skid_instr   <= in_instr;
            skid_imm     <= dec_imm;
            skid_type    <= dec_type;
            skid_illegal <= dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (deliver && out_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule
